node_port_rx: RTL and testbench

Receive end of the node/router link. The transmit side drives `sending_data` and `data_out[15:0]` and watches `buffer_full_in`. This block sits at the router input port and captures those flits into a small FIFO. It drives the back-pressure flag the transmitter sees as `buffer_full_in`, and presents the flits to the router core through a valid/ready interface.

---
 rtl/knock_pkg.sv | 13 +
 rtl/flit_fifo.sv | 80 ++++++++
 rtl/node_port_rx.sv | 69 ++++++
 tb/tb_node_port_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/knock_pkg.sv
// Shared link definitions for the node/router flit link.
// Imported by both the transmit side and the router input port.
package knock_pkg;

   localparam int unsigned FLIT_W = 16;

   typedef logic [FLIT_W-1:0] flit_t;

   // Defaults for the router input port buffer.
   localparam int unsigned RX_DEPTH = 4;
   localparam int unsigned RX_SLACK = 1;

endpackage

// File: rtl/flit_fifo.sv
// Small first-word fall-through flit FIFO with occupancy count.
// A write into a full FIFO is accepted when a pop happens in the same cycle.
module flit_fifo
   import knock_pkg::*;
#(
   parameter int unsigned WIDTH = FLIT_W,
   parameter int unsigned DEPTH = RX_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_req,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop_req,
   output logic                   push_acc,
   output logic                   valid,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic empty;
   logic full;
   logic pop;

   assign empty    = (count_q == '0);
   assign full     = (count_q == DEPTH_CNT);
   assign pop      = pop_req && !empty;
   assign push_acc = push_req && (!full || pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_acc, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   assign valid = !empty;
   assign rdata = mem[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/node_port_rx.sv
// Router input port: captures link flits into a FIFO, raises back-pressure
// early by SLACK entries and flags dropped flits with a sticky overflow bit.
module node_port_rx
   import knock_pkg::*;
#(
   parameter int unsigned WIDTH = FLIT_W,
   parameter int unsigned DEPTH = RX_DEPTH,
   parameter int unsigned SLACK = RX_SLACK
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   receiving_data,
   input  logic [WIDTH-1:0]       data_in,
   output logic                   buffer_full_out,
   output logic                   flit_valid,
   output logic [WIDTH-1:0]       flit_data,
   input  logic                   flit_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   input  logic                   overflow_clr
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_TH = CNT_W'(DEPTH - SLACK);

   logic       push_acc;
   logic       dropped;
   logic       overflow_q, overflow_d;

   flit_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_req (receiving_data),
      .wdata    (data_in),
      .pop_req  (flit_ready),
      .push_acc (push_acc),
      .valid    (flit_valid),
      .rdata    (flit_data),
      .count    (count)
   );

   assign dropped = receiving_data && !push_acc;

   // A drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (dropped) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   // Decoded from the registered count only: no input-to-output path.
   assign buffer_full_out = (count >= FULL_TH);
   assign overflow        = overflow_q;

endmodule

// File: tb/tb_node_port_rx.sv
// Scoreboard bench for node_port_rx with DEPTH=4, SLACK=1.
module tb_node_port_rx;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        receiving_data;
   logic [15:0] data_in;
   logic        buffer_full_out;
   logic        flit_valid;
   logic [15:0] flit_data;
   logic        flit_ready;
   logic [2:0]  count;
   logic        overflow;
   logic        overflow_clr;

   logic [15:0] exp_q[$];
   logic        ovf_m;
   int          vectors;
   int          miscompares;

   node_port_rx dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .receiving_data  (receiving_data),
      .data_in         (data_in),
      .buffer_full_out (buffer_full_out),
      .flit_valid      (flit_valid),
      .flit_data       (flit_data),
      .flit_ready      (flit_ready),
      .count           (count),
      .overflow        (overflow),
      .overflow_clr    (overflow_clr)
   );

   always #5 clk = ~clk;

   // One clock of stimulus; the scoreboard checks every popped head.
   task automatic cycle(input logic rx, input logic [15:0] d, input logic rdy, input logic clr);
      logic pop;
      logic acc;
      receiving_data = rx;
      data_in        = d;
      flit_ready     = rdy;
      overflow_clr   = clr;
      #1;
      pop = rdy && (exp_q.size() != 0);
      acc = rx && ((exp_q.size() < DEPTH) || pop);
      if (pop) begin
         vectors++;
         if (flit_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL pop_data: got %h want %h", flit_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(d);
      if (rx && !acc) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      @(posedge clk);
      #1;
      receiving_data = 1'b0;
      flit_ready     = 1'b0;
      overflow_clr   = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'h5EEE, 1'b0, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd2 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pre: count=%0d ovf=%b want count=2 ovf=1", count, overflow);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (count !== 3'd0 || flit_valid !== 1'b0 || buffer_full_out !== 1'b0 || overflow !== 1'b0)
      begin
         miscompares++;
         $display("FAIL reset_state: count=%0d valid=%b full=%b ovf=%b want 0 0 0 0",
                  count, flit_valid, buffer_full_out, overflow);
      end
      exp_q.delete();
      ovf_m = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (count !== 3'd0 || flit_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: count=%0d valid=%b want 0 0", count, flit_valid);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 3; i++) begin
         cycle(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
         vectors++;
         if (buffer_full_out !== (i == 3) || count !== 3'(i)) begin
            miscompares++;
            $display("FAIL fill_full: push %0d full=%b count=%0d want full=%b count=%0d",
                     i, buffer_full_out, count, (i == 3), i);
         end
      end
      cycle(1'b1, 16'hA004, 1'b0, 1'b0);
      vectors++;
      if (count !== 3'd4 || overflow !== 1'b0 || buffer_full_out !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_slack: count=%0d ovf=%b full=%b want 4 0 1",
                  count, overflow, buffer_full_out);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd0 || flit_valid !== 1'b0 || buffer_full_out !== 1'b0) begin
         miscompares++;
         $display("FAIL drain_end: count=%0d valid=%b full=%b want 0 0 0",
                  count, flit_valid, buffer_full_out);
      end
   endtask

   task automatic test_streaming();
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 16'(i), 1'b1, 1'b0);
         vectors++;
         if (flit_valid !== 1'b1 || count !== 3'd1 || buffer_full_out !== 1'b0) begin
            miscompares++;
            $display("FAIL stream: step %0d valid=%b count=%0d full=%b want 1 1 0",
                     i, flit_valid, count, buffer_full_out);
         end
      end
      cycle(1'b0, 16'h0, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL stream_end: count=%0d left=%0d want 0 0", count, exp_q.size());
      end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd4 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL full_pop: count=%0d ovf=%b want 4 0", count, overflow);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd0) begin
         miscompares++;
         $display("FAIL full_pop_drain: count=%0d want 0", count);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
      vectors++;
      if (overflow !== 1'b1 || count !== 3'd4) begin
         miscompares++;
         $display("FAIL ovf_set: ovf=%b count=%0d want 1 4", overflow, count);
      end
      cycle(1'b1, 16'hDEAD, 1'b0, 1'b1);
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_set_wins: ovf=%b want 1", overflow);
      end
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      vectors++;
      if (overflow !== 1'b0 || count !== 3'd4) begin
         miscompares++;
         $display("FAIL ovf_clr: ovf=%b count=%0d want 0 4", overflow, count);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd0 || flit_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_drain: count=%0d valid=%b want 0 0", count, flit_valid);
      end
   endtask

   task automatic test_pointer_wrap();
      int   pushed;
      logic rx;
      logic rdy;
      pushed = 0;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < 8; c++) begin
            rx  = ($urandom_range(0, 3) != 0) ^ b[0];
            rdy = ($urandom_range(0, 3) != 0) ^ !b[0];
            if (rx) pushed++;
            cycle(rx, 16'($urandom), rdy, 1'($urandom_range(0, 1)));
            vectors++;
            if (count !== 3'(exp_q.size()) || overflow !== ovf_m) begin
               miscompares++;
               $display("FAIL wrap: burst %0d count=%0d ovf=%b want count=%0d ovf=%b",
                        b, count, overflow, exp_q.size(), ovf_m);
            end
         end
      end
      for (int i = 0; i < 6; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0);
      vectors++;
      if (count !== 3'd0 || exp_q.size() != 0 || pushed <= 3 * DEPTH) begin
         miscompares++;
         $display("FAIL wrap_end: count=%0d left=%0d pushed=%0d want 0 0 >12",
                  count, exp_q.size(), pushed);
      end
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      ovf_m          = 1'b0;
      rst_n          = 1'b0;
      receiving_data = 1'b0;
      data_in        = '0;
      flit_ready     = 1'b0;
      overflow_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (count !== 3'd0 || flit_valid !== 1'b0 || buffer_full_out !== 1'b0 || overflow !== 1'b0)
      begin
         miscompares++;
         $display("FAIL por_state: count=%0d valid=%b full=%b ovf=%b want 0 0 0 0",
                  count, flit_valid, buffer_full_out, overflow);
      end
      test_reset();
      test_fill_drain();
      test_streaming();
      test_full_pop();
      test_overflow();
      test_pointer_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
